// File: rtl/delay_calib_ctrl.sv
// Calibration/tracking controller for the buffer/mux cascade delay line.
// Sweeps a delay code up to phase-detector lock, then tracks drift; manual mode forces a code.
module delay_calib_ctrl #(
    parameter int NMBR_CASCADES = 4,
    parameter int SETTLE_CYC    = 8,
    parameter int TRACK_FILT    = 4,
    localparam int MAX          = 2 * NMBR_CASCADES,
    localparam int CW           = $clog2(MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       pd_in,
    input  logic                       man_en,
    input  logic [CW-1:0]              man_code,
    output logic [2*NMBR_CASCADES-1:0] select,
    output logic [CW-1:0]              code,
    output logic                       busy,
    output logic                       locked,
    output logic                       err
);

    localparam int SW = 2 * NMBR_CASCADES;
    localparam int TW = $clog2(SETTLE_CYC);
    localparam int FW = $clog2(TRACK_FILT + 1) + 1;
    localparam logic [CW-1:0]        CODE_MAX = CW'(MAX);
    localparam logic [TW-1:0]        CNT_LAST = TW'(SETTLE_CYC - 1);
    localparam logic signed [FW-1:0] FILT_ONE = FW'(1);
    localparam logic signed [FW-1:0] FILT_POS = FW'(TRACK_FILT);
    localparam logic signed [FW-1:0] FILT_NEG = -FILT_POS;

    typedef enum logic [2:0] {IDLE, SETTLE, EVAL, TRACK, ERROR, MANUAL} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          code_nx, man_clamp;
    logic                   busy_nx, locked_nx, err_nx, restart;
    logic [TW-1:0]          cnt, cnt_nx;
    logic signed [FW-1:0]   filt, filt_nx, filt_vote;
    logic [1:0]             sync;
    logic                   pd_s;

    assign pd_s = sync[1];

    // Stage k carries min(2, max(0, code-2k)) buffer delays.
    function automatic logic [SW-1:0] decode(input logic [CW-1:0] c);
        logic [SW-1:0] s;
        s = '0;
        for (int k = 0; k < NMBR_CASCADES; k++) begin
            if (int'(c) >= 2 * k + 2)
                s[2*k +: 2] = 2'b00;
            else if (int'(c) == 2 * k + 1)
                s[2*k +: 2] = 2'b01;
            else
                s[2*k +: 2] = 2'b10;
        end
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            code   <= '0;
            select <= decode('0);
            busy   <= 1'b0;
            locked <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            filt   <= '0;
            sync   <= '0;
        end else begin
            state  <= state_nx;
            code   <= code_nx;
            select <= decode(code_nx);
            busy   <= busy_nx;
            locked <= locked_nx;
            err    <= err_nx;
            cnt    <= cnt_nx;
            filt   <= filt_nx;
            sync   <= {sync[0], pd_in};
        end
    end

    always_comb begin
        state_nx  = state;
        code_nx   = code;
        busy_nx   = busy;
        locked_nx = locked;
        err_nx    = err;
        cnt_nx    = cnt;
        filt_nx   = filt;
        restart   = 1'b0;
        filt_vote = pd_s ? filt + FILT_ONE : filt - FILT_ONE;
        man_clamp = (man_code > CODE_MAX) ? CODE_MAX : man_code;

        if (man_en) begin
            state_nx  = MANUAL;
            code_nx   = man_clamp;
            busy_nx   = 1'b0;
            locked_nx = 1'b0;
            err_nx    = 1'b0;
            cnt_nx    = '0;
            filt_nx   = '0;
        end else begin
            case (state)
                IDLE:   restart = start;
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx   = '0;
                        state_nx = EVAL;
                    end else begin
                        cnt_nx = cnt + TW'(1);
                    end
                end
                EVAL: begin
                    cnt_nx = '0;
                    if (!pd_s) begin
                        locked_nx = 1'b1;
                        busy_nx   = 1'b0;
                        filt_nx   = '0;
                        state_nx  = TRACK;
                    end else if (code < CODE_MAX) begin
                        code_nx  = code + CW'(1);
                        state_nx = SETTLE;
                    end else begin
                        err_nx   = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = ERROR;
                    end
                end
                TRACK: begin
                    if (start) begin
                        restart = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nx = '0;
                        // A vote that reaches either threshold steps the code and resets the filter.
                        if (filt_vote == FILT_POS) begin
                            filt_nx = '0;
                            if (code < CODE_MAX) code_nx = code + CW'(1);
                        end else if (filt_vote == FILT_NEG) begin
                            filt_nx = '0;
                            if (code != '0) code_nx = code - CW'(1);
                        end else begin
                            filt_nx = filt_vote;
                        end
                    end else begin
                        cnt_nx = cnt + TW'(1);
                    end
                end
                ERROR:  restart = start;
                MANUAL: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase

            if (restart) begin
                state_nx  = SETTLE;
                code_nx   = '0;
                cnt_nx    = '0;
                filt_nx   = '0;
                busy_nx   = 1'b1;
                locked_nx = 1'b0;
                err_nx    = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_delay_calib_ctrl.sv
// Self-checking bench for delay_calib_ctrl: manual vector table, hand-written sweep/track
// sequences, and randomized sweeps/votes against a spec-level model.
module tb_delay_calib_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pd_in;
    logic       man_en;
    logic [3:0] man_code;
    logic [7:0] select;
    logic [3:0] code;
    logic       busy;
    logic       locked;
    logic       err;

    int  checks = 0;
    int  errors = 0;
    int  thr    = 0;
    bit  pd_auto = 1'b0;

    typedef struct {
        logic [3:0] man_code;
        logic [3:0] exp_code;
        logic [7:0] exp_sel;
    } vec_t;

    vec_t vecs[11];

    delay_calib_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pd_in    (pd_in),
        .man_en   (man_en),
        .man_code (man_code),
        .select   (select),
        .code     (code),
        .busy     (busy),
        .locked   (locked),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] model_sel(input int c);
        logic [7:0] s;
        int d;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            d = c - 2 * k;
            if (d > 2) d = 2;
            if (d < 0) d = 0;
            s[2*k +: 2] = (d == 2) ? 2'b00 : (d == 1) ? 2'b01 : 2'b10;
        end
        return s;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock, then inputs/samples 1ns after the edge; pd_in optionally follows "code < thr".
    task automatic step();
        @(posedge clk);
        #1;
        if (pd_auto) pd_in = (int'(code) < thr);
    endtask

    task automatic apply_stimulus(input logic [3:0] mc);
        man_en   = 1'b1;
        man_code = mc;
        step();
    endtask

    task automatic run_sweep(input int t, input bit poke);
        int lock_edge, exp_code;
        exp_code  = (t > 8) ? 8 : t;
        lock_edge = (exp_code + 1) * 9;
        if (t > 8) lock_edge = 81;
        thr     = t;
        pd_auto = 1'b1;
        pd_in   = (0 < t);
        start   = 1'b1;
        step();
        start = 1'b0;
        check_output("sweep_start_busy", 32'(busy), 32'd1);
        check_output("sweep_start_code", 32'(code), 32'd0);
        check_output("sweep_start_flags", 32'({locked, err}), 32'd0);
        for (int n = 1; n < lock_edge; n++) begin
            if (poke && n == 20) start = 1'b1;
            step();
            start = 1'b0;
        end
        check_output("sweep_pre_busy", 32'(busy), 32'd1);
        check_output("sweep_pre_flags", 32'({locked, err}), 32'd0);
        check_output("sweep_pre_code", 32'(code), 32'(exp_code));
        step();
        check_output("sweep_end_busy", 32'(busy), 32'd0);
        check_output("sweep_end_locked", 32'(locked), 32'(t <= 8));
        check_output("sweep_end_err", 32'(err), 32'(t > 8));
        check_output("sweep_end_code", 32'(code), 32'(exp_code));
        check_output("sweep_end_select", 32'(select), 32'(model_sel(exp_code)));
        pd_auto = 1'b0;
    endtask

    initial begin
        int mc, t, mcode, mfilt;
        vecs[0]  = '{4'd0,  4'd0, 8'hAA};
        vecs[1]  = '{4'd1,  4'd1, 8'hA9};
        vecs[2]  = '{4'd2,  4'd2, 8'hA8};
        vecs[3]  = '{4'd3,  4'd3, 8'hA4};
        vecs[4]  = '{4'd4,  4'd4, 8'hA0};
        vecs[5]  = '{4'd5,  4'd5, 8'h90};
        vecs[6]  = '{4'd6,  4'd6, 8'h80};
        vecs[7]  = '{4'd7,  4'd7, 8'h40};
        vecs[8]  = '{4'd8,  4'd8, 8'h00};
        vecs[9]  = '{4'd9,  4'd8, 8'h00};
        vecs[10] = '{4'd15, 4'd8, 8'h00};

        rst = 1'b1; start = 1'b0; pd_in = 1'b0; man_en = 1'b0; man_code = '0;
        step();
        check_output("rst_code", 32'(code), 32'd0);
        check_output("rst_select", 32'(select), 32'hAA);
        check_output("rst_flags", 32'({busy, locked, err}), 32'd0);
        rst = 1'b0;
        step();

        apply_stimulus(4'd3);
        check_output("man3_select", 32'(select), 32'hA4);
        check_output("man3_flags", 32'({busy, locked, err}), 32'd0);
        apply_stimulus(4'd15);
        check_output("man15_code", 32'(code), 32'd8);
        man_en = 1'b0;
        step();
        step();
        check_output("man_release_code", 32'(code), 32'd8);
        check_output("man_release_flags", 32'({busy, locked, err}), 32'd0);

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].man_code);
            check_output($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].exp_code));
            check_output($sformatf("vec%0d_select", i), 32'(select), 32'(vecs[i].exp_sel));
        end
        man_en = 1'b0;
        step();

        start = 1'b1; man_en = 1'b1; man_code = 4'd2;
        step();
        start = 1'b0;
        check_output("start_vs_man_busy", 32'(busy), 32'd0);
        check_output("start_vs_man_code", 32'(code), 32'd2);
        man_en = 1'b0;
        step();

        run_sweep(5, 1'b0);
        pd_in = 1'b1;
        repeat (31) step();
        check_output("track_up_before", 32'(code), 32'd5);
        step();
        check_output("track_up_after", 32'(code), 32'd6);
        pd_in = 1'b0;
        repeat (32) step();
        check_output("track_down_first", 32'(code), 32'd5);
        repeat (160) step();
        check_output("track_down_zero", 32'(code), 32'd0);
        repeat (64) step();
        check_output("track_sat_zero", 32'(code), 32'd0);
        check_output("track_locked", 32'(locked), 32'd1);

        run_sweep(5, 1'b1);

        run_sweep(9, 1'b0);
        repeat (5) step();
        check_output("error_hold", 32'({err, code}), 32'h18);
        start = 1'b1;
        step();
        start = 1'b0;
        check_output("restart_err", 32'(err), 32'd0);
        check_output("restart_busy", 32'(busy), 32'd1);
        check_output("restart_code", 32'(code), 32'd0);
        pd_in = 1'b1;
        repeat (30) step();
        rst = 1'b1;
        #1;
        check_output("midrst_code", 32'(code), 32'd0);
        check_output("midrst_select", 32'(select), 32'hAA);
        check_output("midrst_flags", 32'({busy, locked, err}), 32'd0);
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            mc = $urandom_range(0, 15);
            apply_stimulus(4'(mc));
            check_output("rand_man_code", 32'(code), 32'((mc > 8) ? 8 : mc));
            check_output("rand_man_select", 32'(select), 32'(model_sel((mc > 8) ? 8 : mc)));
        end
        man_en = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            t = $urandom_range(0, 9);
            run_sweep(t, 1'b0);
            if (t <= 8) begin
                mcode = t;
                mfilt = 0;
                for (int v = 0; v < 24; v++) begin
                    pd_in = 1'($urandom_range(0, 1));
                    mfilt += pd_in ? 1 : -1;
                    repeat (8) step();
                    if (mfilt == 4) begin
                        mfilt = 0;
                        if (mcode < 8) mcode++;
                    end else if (mfilt == -4) begin
                        mfilt = 0;
                        if (mcode > 0) mcode--;
                    end
                    check_output("rand_track_code", 32'(code), 32'(mcode));
                end
                check_output("rand_track_select", 32'(select), 32'(model_sel(mcode)));
                check_output("rand_track_locked", 32'(locked), 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
